// File: rtl/flow_bus_pkg.sv
// -----------------------------------------------------------------------------
// flow_bus_pkg
// Shared definitions for the flow-bus serializer family:
//   clog2()       - constant ceil(log2) used to size count ports
//   CW            - count width for the default DATA_NUM of 4
//   norm_count()  - maps a requested beat count onto 1..num
//                   (0 or anything above num means "all sub-words")
//   ser_state_e   - serializer FSM encoding (IDLE / SHIFT)
// No ports (package).
// -----------------------------------------------------------------------------
package flow_bus_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   localparam int DEFAULT_DATA_NUM = 4;
   localparam int CW = clog2(DEFAULT_DATA_NUM + 1);

   function automatic int norm_count(input int count, input int num);
      if ((count == 0) || (count > num)) begin
         return num;
      end
      return count;
   endfunction

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } ser_state_e;

endpackage

// File: rtl/flow_bus_hold_slot.sv
// -----------------------------------------------------------------------------
// flow_bus_hold_slot
// One-entry registered buffer for a wide word plus its beat count. Lets the
// serializer accept the next up word while the current one is still shifting.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid_i      push request (only honoured while in_ready_o is high)
//   in_ready_o      slot empty; registered, held low during reset
//   in_data_i       word to store
//   in_count_i      normalised beat count to store
//   out_valid_o     slot holds a word
//   out_ready_i     consumer takes the stored word this cycle
//   out_data_o      stored word
//   out_count_o     stored beat count
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; valid never depends combinationally on ready.
// -----------------------------------------------------------------------------
module flow_bus_hold_slot #(
   parameter int DW    = 32,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [DW-1:0]    in_data_i,
   input  logic [CNT_W-1:0] in_count_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [DW-1:0]    out_data_o,
   output logic [CNT_W-1:0] out_count_o
);

   logic             valid_q;
   logic             valid_d;
   logic             ready_q;
   logic [DW-1:0]    data_q;
   logic [CNT_W-1:0] count_q;
   logic             push;
   logic             pop;

   assign push = in_valid_i & ready_q;
   assign pop  = out_ready_i & valid_q;

   always_comb begin
      valid_d = valid_q;
      if (push) begin
         valid_d = 1'b1;
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   // ready_q mirrors ~valid_q but is its own register so it can sit low in reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         ready_q <= 1'b0;
         data_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         ready_q <= ~valid_d;
         if (push) begin
            data_q  <= in_data_i;
            count_q <= in_count_i;
         end
      end
   end

   assign in_ready_o  = ready_q;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign out_count_o = count_q;

endmodule

// File: rtl/flow_bus_serializer_v2.sv
// -----------------------------------------------------------------------------
// flow_bus_serializer_v2
// Splits one wide up word (DATA_NUM sub-words of DATA_WIDTH bits) into a
// stream of down beats. up_count selects how many sub-words are emitted
// (0 or > DATA_NUM means all); MSB_FIRST selects which end is emitted first;
// down_last flags the final beat of each word.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   up_ready     can accept an up word (registered)
//   up_valid     up word present
//   up_data      wide word, sampled only on the up handshake
//   up_count     beats to emit, sampled only on the up handshake
//   down_ready   consumer accepts the current beat
//   down_valid   beat present (registered)
//   down_data    current beat (register slice)
//   down_last    final beat of the word (registered)
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. Once down_valid rises it stays high, with down_data/down_last
// stable, until the beat is taken; it never drops inside a word.
// Build option: define FLOW_BUS_SERIALIZER_PREFETCH_EN to add a one-entry hold
// slot so the next word is queued during shifting and streams follow with no
// idle cycle. Without it up_ready is simply ~busy and one idle cycle separates
// consecutive words.
// -----------------------------------------------------------------------------
module flow_bus_serializer_v2
   import flow_bus_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_NUM   = 4,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic                               clk,
   input  logic                               rst,
   output logic                               up_ready,
   input  logic                               up_valid,
   input  logic [DATA_WIDTH*DATA_NUM-1:0]     up_data,
   input  logic [clog2(DATA_NUM+1)-1:0]       up_count,
   input  logic                               down_ready,
   output logic                               down_valid,
   output logic [DATA_WIDTH-1:0]              down_data,
   output logic                               down_last
);

   localparam int TW    = DATA_WIDTH * DATA_NUM;
   localparam int CNT_W = clog2(DATA_NUM + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

   ser_state_e       state_q;
   logic [TW-1:0]    sh_q;
   logic [TW-1:0]    sh_shift;
   logic [CNT_W-1:0] rem_q;
   logic             down_valid_q;
   logic             down_last_q;

   logic [CNT_W-1:0] up_cnt_eff;
   logic             last_fire;   // final beat of the current word is taken
   logic             up_take;     // up word goes straight into the shifter
   logic             hold_take;   // held word goes into the shifter
   logic [TW-1:0]    hold_data;
   logic [CNT_W-1:0] hold_count;
   logic [TW-1:0]    load_data;
   logic [CNT_W-1:0] load_count;

   assign up_cnt_eff = CNT_W'(norm_count(int'(up_count), DATA_NUM));
   assign last_fire  = (state_q == ST_SHIFT) & down_ready & (rem_q == CNT_ONE);

`ifdef FLOW_BUS_SERIALIZER_PREFETCH_EN
   logic up_fire;
   logic hold_ready;
   logic hold_valid;
   logic hold_push;

   assign up_fire   = up_valid & hold_ready;
   // A word arriving while the shifter is free (idle, or finishing with the
   // slot empty) bypasses the slot; otherwise it is parked in the slot.
   // up_fire implies the slot is empty, so it never races the handover.
   assign up_take   = up_fire & ((state_q == ST_IDLE) | last_fire);
   assign hold_push = up_fire & ~up_take;
   assign hold_take = last_fire & hold_valid;
   assign up_ready  = hold_ready;

   flow_bus_hold_slot #(
      .DW    (TW),
      .CNT_W (CNT_W)
   ) u_hold_slot (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (hold_push),
      .in_ready_o  (hold_ready),
      .in_data_i   (up_data),
      .in_count_i  (up_cnt_eff),
      .out_valid_o (hold_valid),
      .out_ready_i (last_fire),
      .out_data_o  (hold_data),
      .out_count_o (hold_count)
   );
`else
   logic up_ready_q;
   logic busy_next;

   assign up_take    = up_valid & up_ready_q;
   assign hold_take  = 1'b0;
   assign hold_data  = '0;
   assign hold_count = '0;
   assign up_ready   = up_ready_q;

   // up_ready is ~busy for the next cycle, so it rises the cycle after the
   // last beat and a new word's first beat appears one cycle later.
   assign busy_next = (state_q == ST_IDLE) ? up_take : ~last_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         up_ready_q <= 1'b0;
      end else begin
         up_ready_q <= ~busy_next;
      end
   end
`endif

   assign load_data  = hold_take ? hold_data  : up_data;
   assign load_count = hold_take ? hold_count : up_cnt_eff;

   // Shift toward the emitting end; zeros fill the vacated sub-word.
   always_comb begin
      sh_shift = sh_q;
      if (MSB_FIRST) begin
         sh_shift = sh_q << DATA_WIDTH;
      end else begin
         sh_shift = sh_q >> DATA_WIDTH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sh_q         <= '0;
         rem_q        <= '0;
         down_valid_q <= 1'b0;
         down_last_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (up_take) begin
                  sh_q         <= up_data;
                  rem_q        <= up_cnt_eff;
                  down_valid_q <= 1'b1;
                  down_last_q  <= (up_cnt_eff == CNT_ONE);
                  state_q      <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (down_ready) begin
                  if (rem_q != CNT_ONE) begin
                     sh_q        <= sh_shift;
                     rem_q       <= rem_q - CNT_ONE;
                     down_last_q <= (rem_q == CNT_TWO);
                  end else if (hold_take | up_take) begin
                     sh_q        <= load_data;
                     rem_q       <= load_count;
                     down_last_q <= (load_count == CNT_ONE);
                  end else begin
                     rem_q        <= '0;
                     down_valid_q <= 1'b0;
                     down_last_q  <= 1'b0;
                     state_q      <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   if (MSB_FIRST) begin : g_msb_first
      assign down_data = sh_q[TW-1 -: DATA_WIDTH];
   end else begin : g_lsb_first
      assign down_data = sh_q[DATA_WIDTH-1:0];
   end

   assign down_valid = down_valid_q;
   assign down_last  = down_last_q;

endmodule

// File: tb/tb_flow_bus_serializer_v2.sv
// -----------------------------------------------------------------------------
// tb_flow_bus_serializer_v2
// Bench for flow_bus_serializer_v2 (DATA_WIDTH=8, DATA_NUM=4). dut0 uses
// MSB_FIRST=0, dut1 uses MSB_FIRST=1. Expected beats {last,data} are queued
// when an up word is accepted and popped by a negedge monitor per DUT.
// -----------------------------------------------------------------------------
module tb_flow_bus_serializer_v2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        up_valid, up_ready, down_ready, down_valid, down_last;
   logic [31:0] up_data;
   logic [2:0]  up_count;
   logic [7:0]  down_data;

   logic        up_valid1, up_ready1, down_ready1, down_valid1, down_last1;
   logic [31:0] up_data1;
   logic [2:0]  up_count1;
   logic [7:0]  down_data1;

   flow_bus_serializer_v2 #(.DATA_WIDTH(8), .DATA_NUM(4), .MSB_FIRST(1'b0)) dut0 (
      .clk        (clk),
      .rst        (rst),
      .up_ready   (up_ready),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .up_count   (up_count),
      .down_ready (down_ready),
      .down_valid (down_valid),
      .down_data  (down_data),
      .down_last  (down_last)
   );

   flow_bus_serializer_v2 #(.DATA_WIDTH(8), .DATA_NUM(4), .MSB_FIRST(1'b1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .up_ready   (up_ready1),
      .up_valid   (up_valid1),
      .up_data    (up_data1),
      .up_count   (up_count1),
      .down_ready (down_ready1),
      .down_valid (down_valid1),
      .down_data  (down_data1),
      .down_last  (down_last1)
   );

   // ---------------- scoreboard ----------------
   logic [8:0] exp_q[$];
   logic [8:0] exp1_q[$];
   int tests_run    = 0;
   int tests_failed = 0;
   int beats_seen   = 0;
   int beats1_seen  = 0;

   always @(negedge clk) begin
      if (down_valid && down_ready) begin
         logic [8:0] e;
         beats_seen++;
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL dut0_beat: got last=%b data=%h, expected no beat", down_last, down_data);
         end else begin
            e = exp_q.pop_front();
            if ({down_last, down_data} !== e) begin
               tests_failed++;
               $display("FAIL dut0_beat: got last=%b data=%h, expected last=%b data=%h",
                        down_last, down_data, e[8], e[7:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (down_valid1 && down_ready1) begin
         logic [8:0] e;
         beats1_seen++;
         tests_run++;
         if (exp1_q.size() == 0) begin
            tests_failed++;
            $display("FAIL dut1_beat: got last=%b data=%h, expected no beat", down_last1, down_data1);
         end else begin
            e = exp1_q.pop_front();
            if ({down_last1, down_data1} !== e) begin
               tests_failed++;
               $display("FAIL dut1_beat: got last=%b data=%h, expected last=%b data=%h",
                        down_last1, down_data1, e[8], e[7:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   // ---------------- driver tasks ----------------
   function automatic int eff_count(input logic [2:0] c);
      return ((c == 3'd0) || (c > 3'd4)) ? 4 : int'(c);
   endfunction

   task automatic push_word(input int sel, input logic [31:0] w, input logic [2:0] c);
      int n;
      int idx;
      logic [31:0] s;
      n = eff_count(c);
      for (int i = 0; i < n; i++) begin
         idx = (sel == 1) ? (3 - i) : i;
         s = w >> (8 * idx);
         if (sel == 1) exp1_q.push_back({(i == n - 1), s[7:0]});
         else          exp_q.push_back({(i == n - 1), s[7:0]});
      end
   endtask

   // Called #1 after a posedge; returns #1 after the handshake edge.
   task automatic send_word(input int sel, input logic [31:0] w, input logic [2:0] c);
      logic rdy;
      bit   done;
      done = 0;
      if (sel == 1) begin
         up_valid1 = 1'b1; up_data1 = w; up_count1 = c;
      end else begin
         up_valid = 1'b1; up_data = w; up_count = c;
      end
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         rdy = (sel == 1) ? up_ready1 : up_ready;
         if (rdy) push_word(sel, w, c);
         @(posedge clk);
         #1;
         if (rdy) begin
            done = 1;
            break;
         end
      end
      if (sel == 1) up_valid1 = 1'b0;
      else          up_valid  = 1'b0;
      tests_run++;
      if (!done) begin
         tests_failed++;
         $display("FAIL send_accept: got up_ready never high, expected handshake within 100 cycles");
      end
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      down_ready = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !down_valid) begin
            ok = 1;
            break;
         end
      end
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL drain: got %0d beats pending, expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      up_valid = 1'b1; up_data = 32'hFFFF_FFFF; up_count = 3'd0; down_ready = 1'b1;
      up_valid1 = 1'b0; up_data1 = '0; up_count1 = 3'd0; down_ready1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run += 4;
         if (up_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_up_ready: got %b expected 0", up_ready);
         end
         if (down_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_down_valid: got %b expected 0", down_valid);
         end
         if (down_data !== 8'h00) begin
            tests_failed++; $display("FAIL reset_down_data: got %h expected 00", down_data);
         end
         if (down_last !== 1'b0) begin
            tests_failed++; $display("FAIL reset_down_last: got %b expected 0", down_last);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      up_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (up_ready !== 1'b0) begin
         tests_failed++; $display("FAIL release_up_ready_early: got %b expected 0", up_ready);
      end
      @(negedge clk);
      tests_run++;
      if (up_ready !== 1'b1) begin
         tests_failed++; $display("FAIL release_up_ready: got %b expected 1", up_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int b0;
      down_ready = 1'b1;
      b0 = beats_seen;
      send_word(0, 32'hDDCC_BBAA, 3'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests_run++;
         if (down_valid !== 1'b1) begin
            tests_failed++; $display("FAIL basic_valid[%0d]: got %b expected 1", i, down_valid);
         end
      end
      @(negedge clk);
      tests_run += 2;
      if (down_valid !== 1'b0) begin
         tests_failed++; $display("FAIL basic_valid_end: got %b expected 0", down_valid);
      end
      if (beats_seen - b0 !== 4) begin
         tests_failed++; $display("FAIL basic_beats: got %0d expected 4", beats_seen - b0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_order();
      int b0;
      b0 = beats1_seen;
      send_word(1, 32'h4433_2211, 3'd2);
      for (int i = 0; i < 5; i++) @(negedge clk);
      tests_run += 2;
      if (beats1_seen - b0 !== 2) begin
         tests_failed++; $display("FAIL order_beats: got %0d expected 2", beats1_seen - b0);
      end
      if (exp1_q.size() !== 0) begin
         tests_failed++; $display("FAIL order_pending: got %0d expected 0", exp1_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_counts();
      logic [2:0] cnts[4] = '{3'd1, 3'd3, 3'd7, 3'd2};
      int b0;
      for (int i = 0; i < 4; i++) begin
         b0 = beats_seen;
         send_word(0, $urandom, cnts[i]);
         drain();
         tests_run++;
         if (beats_seen - b0 !== eff_count(cnts[i])) begin
            tests_failed++;
            $display("FAIL count_beats(c=%0d): got %0d expected %0d", cnts[i], beats_seen - b0,
                     eff_count(cnts[i]));
         end
      end
   endtask

   task automatic test_backpressure();
      bit         pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bit         stalled;
      logic [7:0] pd;
      logic       pl;
      stalled = 0;
      pd = '0;
      pl = 1'b0;
      down_ready = 1'b1;
      send_word(0, 32'hDDCC_BBAA, 3'd0);
      for (int c = 0; c < 40; c++) begin
         down_ready = pat[c % 4];
         @(negedge clk);
         if (stalled) begin
            tests_run++;
            if (down_valid !== 1'b1 || down_data !== pd || down_last !== pl) begin
               tests_failed++;
               $display("FAIL stall_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                        down_valid, down_data, down_last, pd, pl);
            end
         end
         stalled = down_valid && !down_ready;
         pd = down_data;
         pl = down_last;
         if (exp_q.size() == 0 && !down_valid) break;
         @(posedge clk);
         #1;
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int c4, c5, want;
      c4 = -1;
      c5 = -1;
`ifdef FLOW_BUS_SERIALIZER_PREFETCH_EN
      want = 1;
`else
      want = 2;
`endif
      down_ready = 1'b1;
      fork
         begin
            send_word(0, 32'h0403_0201, 3'd0);
            send_word(0, 32'h0807_0605, 3'd0);
         end
         begin
            for (int c = 0; c < 20; c++) begin
               @(negedge clk);
               if (down_valid && down_ready && down_data == 8'h04) c4 = c;
               if (down_valid && down_ready && down_data == 8'h05) c5 = c;
            end
         end
      join
      tests_run++;
      if (c4 < 0 || c5 < 0 || (c5 - c4) !== want) begin
         tests_failed++;
         $display("FAIL b2b_gap: got %0d cycles (04@%0d 05@%0d) expected %0d", c5 - c4, c4, c5, want);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      int b0;
      down_ready = 1'b1;
      b0 = beats_seen;
      send_word(0, 32'hDDCC_BBAA, 3'd0);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1;
      tests_run++;
      if (beats_seen - b0 !== 2) begin
         tests_failed++; $display("FAIL midrst_pre_beats: got %0d expected 2", beats_seen - b0);
      end
      rst = 1'b1;
      down_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      down_ready = 1'b1;
      b0 = beats_seen;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (down_valid !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_valid[%0d]: got %b expected 0", i, down_valid);
         end
      end
      tests_run++;
      if (beats_seen !== b0) begin
         tests_failed++; $display("FAIL midrst_no_beats: got %0d expected 0", beats_seen - b0);
      end
      @(posedge clk);
      #1;
      b0 = beats_seen;
      send_word(0, 32'h0D0C_0B0A, 3'd0);
      drain();
      tests_run++;
      if (beats_seen - b0 !== 4) begin
         tests_failed++; $display("FAIL midrst_next_beats: got %0d expected 4", beats_seen - b0);
      end
   endtask

   task automatic test_random();
      bit send_done;
      send_done = 0;
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               send_word(0, $urandom, 3'($urandom_range(0, 7)));
               if ($urandom_range(0, 2) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            send_done = 1;
         end
         begin
            for (int k = 0; k < 800 && !send_done; k++) begin
               down_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
         end
      join
      drain();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      test_reset();
      test_basic();
      test_order();
      test_counts();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      tests_run += 2;
      if (exp_q.size() !== 0) begin
         tests_failed++; $display("FAIL final_pending0: got %0d expected 0", exp_q.size());
      end
      if (exp1_q.size() !== 0) begin
         tests_failed++; $display("FAIL final_pending1: got %0d expected 0", exp1_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/flow_bus_serializer_v2.md
# flow_bus_serializer_v2

Parametrised serializer converting one wide flow-bus word of up to DATA_NUM sub-words into a stream of DATA_WIDTH beats with full valid/ready back-pressure. Supports a per-word beat count, selectable word order and an end-of-word marker. Sits between wide producers (FIFO read ports, DMA engines) and narrow consumers (host pipe, byte-wide links) in the flow-bus fabric.

## Interface
- DATA_WIDTH, 8, width of one down beat
- DATA_NUM, 4, max sub-words per up word (>=2)
- MSB_FIRST, 0, 0: sub-word 0 (bits DATA_WIDTH-1:0) emitted first; 1: highest sub-word first
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- up_ready  out  1  serializer can accept an up word this cycle
- up_valid  in  1  up word present
- up_data  in  DATA_WIDTH*DATA_NUM  wide word
- up_count  in  CW=clog2(DATA_NUM+1)  beats to emit; 0 or >DATA_NUM treated as DATA_NUM
- down_ready  in  1  consumer accepts beat
- down_valid  out  1  beat present
- down_data  out  DATA_WIDTH  current beat
- down_last  out  1  final beat of current up word

## Operation
- Up handshake: up_valid & up_ready. Down handshake: down_valid & down_ready.
- Core: shift register sh (DATA_WIDTH*DATA_NUM), beat counter rem (CW bits), flag busy.
- States: IDLE (busy=0) and SHIFT (busy=1).
- IDLE + up handshake: sh <= up_data, rem <= effective count, busy <= 1.
- SHIFT: down_valid=1; down_data = sh low sub-word (MSB_FIRST=0) or high sub-word (MSB_FIRST=1); down_last = (rem==1).
- SHIFT + down handshake, rem>1: sh shifts by DATA_WIDTH toward the emitting end, rem decrements.
- SHIFT + down handshake, rem==1: word done; reload from next source (see Configuration) or return to IDLE.
- down_valid never drops mid-word; down_data/down_last stable while down_valid & ~down_ready.
- up_data/up_count sampled only on up handshake; changes otherwise ignored.
- Reset mid-word: in-flight and held words discarded, no further beats emitted.

## Timing
- Reset values: down_valid=0, down_last=0, down_data=0, busy=0, rem=0; up_ready=0 while rst high, 1 the cycle after rst falls.
- Latency: up handshake at cycle t -> first beat valid at t+1.
- Outputs down_* driven from registers only; no combinational up->down path.
- Beat count N, no stalls: beats at t+1..t+N; down_last at t+N.
- down_ready held low: state frozen, no beat lost or duplicated.
- up_count=1: single beat with down_last=1.

## Configuration
- Macro FLOW_BUS_SERIALIZER_PREFETCH_EN.
- Undefined: up_ready = ~busy (registered). After last beat at t, up_ready rises at t+1; next word's first beat at t+2 earliest; throughput N beats per N+1 cycles.
- Defined: one-entry hold slot (data+count). up_ready = ~hold_valid (registered). In IDLE up word loads sh directly; in SHIFT it loads the hold slot. On last-beat handshake with hold_valid, sh/rem load from hold next cycle, hold_valid clears: zero-bubble streams, N beats per N cycles. Hold slot and its last-beat handover happen the same cycle as a new up handshake only if hold empty at cycle start; up handshake and handover never conflict.

## Structure
- Package flow_bus_pkg: clog2 constant function, count-width constant CW, effective-count normalisation function (0/overflow -> DATA_NUM).
- Sub-module flow_bus_hold_slot: one-entry registered data+count buffer with valid/ready; instantiated only under FLOW_BUS_SERIALIZER_PREFETCH_EN.

## Test plan
- Reset: rst high 3 cycles with up_valid=1 -> up_ready=0, down_valid=0, down_data=0 throughout; up_ready=1 the cycle after release.
- Basic: DATA_WIDTH=8, DATA_NUM=4, MSB_FIRST=0, up_data=0xDDCCBBAA, up_count=0, down_ready=1 -> beats AA,BB,CC,DD on cycles t+1..t+4, down_last only on DD.
- Order/count: MSB_FIRST=1, up_data=0x44332211, up_count=2 -> beats 44,33; down_last on 33; 22/11 never emitted.
- Back-pressure: down_ready toggled 1,0,0,1,... -> each beat held stable while stalled; sequence identical to basic case.
- Back-to-back: two words 0x04030201, 0x08070605, up_valid continuous -> without macro one idle cycle between 04 and 05; with macro 05 immediately follows 04.
- Reset mid-word: rst asserted after second beat of 0xDDCCBBAA -> down_valid=0 next cycle, no CC/DD afterward; next word serializes cleanly from its first beat.
